rr_arbiter_1hot_8: RTL
======================

Name: rr_arbiter_1hot_8

Overview:
- Round-robin arbiter that shares one resource among 8 requesters.
- Registers a one-hot grant plus its 3-bit encoded index. The index drives the select of a shared 8:1 datapath.
- A grant is held until its requester drops `req`, or until a hold-time limit expires.
- A one-cycle turnaround gap follows every release, so the downstream mux never switches owners back-to-back.

Parameters:
- `MAX_HOLD`, default 16: maximum consecutive cycles a single grant may be held. Legal range 1..255.
- `HOLD_W`, default 8: width of the internal hold counter. Must satisfy 2^HOLD_W > `MAX_HOLD`.

Ports:
- `clk`  input  1  system clock, rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `req_in`  input  8  per-requester request; bit i = requester i. Level-sensitive.
- `grant_out`  output  8  one-hot grant, registered. All-zero when nobody owns the resource.
- `grant_idx_out`  output  3  binary index of the granted requester. Valid only while `grant_valid_out` = 1.
- `grant_valid_out`  output  1  high while a grant is active.
- `timeout_out`  output  1  one-cycle pulse when a grant is revoked by `MAX_HOLD` expiry.

Behaviour:
- **Reset (async assert, sync deassert at the flop level):**
  - `grant_out` = 8'h00, `grant_idx_out` = 3'b000, `grant_valid_out` = 0, `timeout_out` = 0.
  - state = IDLE, pointer = 3'd7, hold counter = 0.
  - Reset mid-grant drops the grant immediately; no timeout pulse.
- **States:** IDLE, BUSY, GAP.
- **IDLE:**
  - If `req_in` != 0, pick the first set bit searching upward from pointer+1 (mod 8), wrapping.
  - Next edge: `grant_out` = that one-hot bit, `grant_idx_out` = its index, `grant_valid_out` = 1, pointer = winner, hold counter = 1, state → BUSY.
  - Latency from `req` seen in IDLE to grant visible: 1 cycle.
- **BUSY:**
  - If `req_in[idx]` = 0: next edge clears the grant outputs (valid = 0, grant = 0) and state → GAP.
  - Else if hold counter == `MAX_HOLD`: next edge clears the grant, pulses `timeout_out` for 1 cycle, and state → GAP.
  - Else: increment the hold counter and keep the grant.
  - Result: a continuously requesting owner holds the grant for exactly `MAX_HOLD` cycles.
  - Other requests arriving during BUSY are ignored; they are not queued and are sampled again in IDLE.
- **GAP:**
  - Exactly one cycle with no grant; `req_in` is ignored.
  - State → IDLE. The earliest next grant appears 2 cycles after the release edge.
- **Fairness:**
  - The pointer is updated only on a grant.
  - Immediately after a timeout, the timed-out requester has lowest priority. If it is still the only requester, it is re-granted after the GAP.
- **`grant_idx_out`:** combinational encode of the registered `grant_out`. The encoder's don't-care (X) for non-one-hot input is masked: when `grant_valid_out` = 0, drive 3'b000.
- **Invariants:**
  - `grant_out` is one-hot or zero.
  - `grant_valid_out` == |`grant_out`.
  - `timeout_out` is never high while `grant_valid_out` = 1.

Decomposition:
- Shared package holds:
  - state enum {IDLE, BUSY, GAP};
  - `N_REQ` = 8 and `IDX_W` = 3 constants;
  - the pointer reset value 3'd7.
- One sub-module is natural: instantiate the existing `encoder_1hot_8to3` to produce `grant_idx_out` from `grant_out`, with the valid mask applied in this block.
- The rotate-and-priority-select stays inline as combinational logic.

Test Plan:
- Reset with `req_in` = 8'hFF held → all outputs 0 during reset. First edge after release: `grant_out` = 8'h01, idx = 0. Holds for 16 cycles, then `timeout_out` pulses. GAP, then `grant_out` = 8'h02, idx = 1.
- `req_in` = 8'h20 for 3 cycles then 0 → grant 8'h20 / idx 5 for 3 cycles, no timeout. Valid = 0 for the GAP cycle and afterwards.
- `req_in` = 8'h81, pointer = 7 after reset → grant bit 0. Drop bit 0 → GAP → grant 8'h80 / idx 7. Drop bit 7, re-raise 8'h81 → grant bit 0 (wrap-around fairness).
- Only bit 3 requesting continuously, `MAX_HOLD` = 4 → grant 4 cycles, timeout pulse, 1 GAP cycle, re-grant bit 3. Repeats with period 6.
- Assert `rst_n` = 0 mid-BUSY on idx 6 → `grant_out` = 0 asynchronously, no `timeout_out`. After release with `req_in` = 8'h40 → grant idx 6 one cycle later.
- Random `req_in` for 10k cycles → one-hot/valid invariants hold. No requester starves beyond 7 × (`MAX_HOLD` + 1) + 8 cycles.

Source files
------------

// File: rtl/rr_arbiter_1hot_8_pkg.sv
// Shared types and constants for the 8-way round-robin arbiter.
package rr_arbiter_1hot_8_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    // Pointer starts at the top so requester 0 has first priority out of reset.
    localparam logic [IDX_W-1:0] PTR_RESET = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter_1hot_8_encoder.sv
// One-hot to binary encoder; non-one-hot input yields the OR of set indices.
module encoder_1hot_8to3 (
    input  logic [7:0] onehot_i,
    output logic [2:0] idx_o
);

    always_comb begin
        idx_o = '0;
        for (int i = 0; i < 8; i++) begin
            if (onehot_i[i]) begin
                idx_o = idx_o | 3'(i);
            end
        end
    end

endmodule

// File: rtl/rr_arbiter_1hot_8.sv
// Round-robin arbiter for 8 requesters with hold-time limit and a one-cycle
// turnaround gap after every release.
module rr_arbiter_1hot_8
    import rr_arbiter_1hot_8_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int HOLD_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req_in,
    output logic [N_REQ-1:0]     grant_out,
    output logic [IDX_W-1:0]     grant_idx_out,
    output logic                 grant_valid_out,
    output logic                 timeout_out
);

    arb_state_e          state_q;
    logic [N_REQ-1:0]    grant_q;
    logic                valid_q;
    logic                timeout_q;
    logic [IDX_W-1:0]    ptr_q;
    logic [HOLD_W-1:0]   hold_q;

    logic                found;
    logic [IDX_W-1:0]    win_idx;
    logic [IDX_W-1:0]    cand;
    logic [N_REQ-1:0]    win_onehot;
    logic [IDX_W-1:0]    enc_idx;

    // Search upward from pointer+1; the 3-bit sum wraps modulo 8 on its own.
    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand = ptr_q + IDX_W'(i);
            if (!found && req_in[cand]) begin
                win_idx = cand;
                found   = 1'b1;
            end
        end
        win_onehot = N_REQ'(1) << win_idx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            ptr_q     <= PTR_RESET;
            hold_q    <= '0;
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (found) begin
                        grant_q <= win_onehot;
                        valid_q <= 1'b1;
                        ptr_q   <= win_idx;
                        hold_q  <= HOLD_W'(1);
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    if ((req_in & grant_q) == '0) begin
                        grant_q <= '0;
                        valid_q <= 1'b0;
                        state_q <= GAP;
                    end else if (hold_q == HOLD_W'(MAX_HOLD)) begin
                        grant_q   <= '0;
                        valid_q   <= 1'b0;
                        timeout_q <= 1'b1;
                        state_q   <= GAP;
                    end else begin
                        hold_q <= hold_q + HOLD_W'(1);
                    end
                end
                GAP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    encoder_1hot_8to3 u_enc (
        .onehot_i (grant_q),
        .idx_o    (enc_idx)
    );

    assign grant_out       = grant_q;
    assign grant_valid_out = valid_q;
    assign timeout_out     = timeout_q;
    assign grant_idx_out   = valid_q ? enc_idx : '0;

endmodule
